// File: rtl/memory_instruction_queue_pkg.sv
// memory_instruction_queue_pkg: memory-instruction word layout shared by the control unit and the queue
package memory_instruction_queue_pkg;
  localparam int MAB_DEFAULT = 15;
  localparam int TARGET_W = 2;
  localparam int HEIGHT_W = 5;
  localparam int WIDTH_W = 5;
  localparam int HDR_W = 1 + TARGET_W + HEIGHT_W + WIDTH_W + 2;
  function automatic int mem_instr_width(input int mab);
    return 6 * mab + HDR_W;
  endfunction
  typedef enum logic [TARGET_W-1:0] {TGT_0 = 2'd0, TGT_1 = 2'd1, TGT_2 = 2'd2, TGT_3 = 2'd3} mem_target_e;
  typedef struct packed {
    logic is_load;
    mem_target_e target;
    logic [HEIGHT_W-1:0] height;
    logic [WIDTH_W-1:0] width;
    logic zero_flag;
    logic skip_flag;
    logic signed [MAB_DEFAULT-1:0] addr;
    logic signed [MAB_DEFAULT-1:0] stridex;
    logic signed [MAB_DEFAULT-1:0] stridey;
    logic signed [MAB_DEFAULT-1:0] daddr;
    logic signed [MAB_DEFAULT-1:0] dstridex;
    logic signed [MAB_DEFAULT-1:0] dstridey;
  } mem_instr_t;
endpackage

// File: rtl/memory_instruction_queue_sync_fifo.sv
// sync_fifo: registered FIFO with count, full/empty and a synchronous clear
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 full,
  output logic                 empty,
  output logic [LOG_DEPTH:0]   count
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_q, rd_q;
  logic [LOG_DEPTH:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (LOG_DEPTH+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  // full is judged before any same-cycle pop, so a push into a full queue is always dropped
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + LOG_DEPTH'(do_push);
      rd_q <= rd_q + LOG_DEPTH'(do_pop);
      cnt_q <= cnt_q + (LOG_DEPTH+1)'(do_push) - (LOG_DEPTH+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !clr) mem_q[wr_q] <= din;
endmodule

// File: rtl/memory_instruction_queue.sv
// memory_instruction_queue: buffers packed memory instructions and replays each copy_count+1 times with address deltas
module memory_instruction_queue
  import memory_instruction_queue_pkg::*;
#(
  parameter int MEMORY_ADDRESS_BITS = MAB_DEFAULT,
  parameter int SUPERSCALAR_LOG_WIDTH = 2,
  parameter int QUEUE_LOG_DEPTH = 3,
  parameter int MEM_INSTR_WIDTH = mem_instr_width(MEMORY_ADDRESS_BITS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [MEM_INSTR_WIDTH-1:0]       memory_instructions,
  input  logic                             memory_instruction_we,
  input  logic [SUPERSCALAR_LOG_WIDTH-1:0] copy_count,
  output logic                             queue_full,
  output logic                             queue_almost_full,
  output logic [QUEUE_LOG_DEPTH:0]         occupancy,
  output logic                             overflow_error,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_is_load,
  output logic [TARGET_W-1:0]              out_target,
  output logic [HEIGHT_W-1:0]              out_height,
  output logic [WIDTH_W-1:0]               out_width,
  output logic                             out_zero_flag,
  output logic                             out_skip_flag,
  output logic [MEMORY_ADDRESS_BITS-1:0]   out_addr,
  output logic [MEMORY_ADDRESS_BITS-1:0]   out_stridex,
  output logic [MEMORY_ADDRESS_BITS-1:0]   out_stridey,
  output logic [SUPERSCALAR_LOG_WIDTH-1:0] out_copy_index,
  output logic                             out_last_copy
);
  localparam int MAB = MEMORY_ADDRESS_BITS;
  localparam int SLW = SUPERSCALAR_LOG_WIDTH;
  logic [MEM_INSTR_WIDTH+SLW-1:0] head;
  logic [MEM_INSTR_WIDTH-1:0] word;
  logic [SLW-1:0] head_cc, idx_q, idx_d;
  logic [MAB-1:0] h_addr, h_sx, h_sy, h_daddr, h_dsx, h_dsy;
  logic [MAB-1:0] off_addr_q, off_addr_d, off_sx_q, off_sx_d, off_sy_q, off_sy_d;
  logic fire, empty, overflow_q, overflow_d;
  sync_fifo #(.WIDTH(MEM_INSTR_WIDTH + SLW), .LOG_DEPTH(QUEUE_LOG_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .clr   (flush),
    .push  (memory_instruction_we),
    .pop   (fire && out_last_copy),
    .din   ({memory_instructions, copy_count}),
    .dout  (head),
    .full  (queue_full),
    .empty (empty),
    .count (occupancy)
  );
  assign {word, head_cc} = head;
  assign {out_is_load, out_target, out_height, out_width, out_zero_flag, out_skip_flag,
          h_addr, h_sx, h_sy, h_daddr, h_dsx, h_dsy} = word;
  assign out_valid = !empty;
  assign queue_almost_full = occupancy >= (QUEUE_LOG_DEPTH+1)'((1 << QUEUE_LOG_DEPTH) - 1);
  assign overflow_error = overflow_q;
  assign fire = out_valid && out_ready;
  assign out_copy_index = idx_q;
  assign out_last_copy = idx_q == head_cc;
  assign out_addr = h_addr + off_addr_q;
  assign out_stridex = h_sx + off_sx_q;
  assign out_stridey = h_sy + off_sy_q;
  // the last copy pops the entry, so the replay state restarts at zero for the next head
  always_comb begin
    idx_d = (flush || (fire && out_last_copy)) ? '0 : fire ? idx_q + 1'b1 : idx_q;
    off_addr_d = (flush || (fire && out_last_copy)) ? '0 : fire ? off_addr_q + h_daddr : off_addr_q;
    off_sx_d = (flush || (fire && out_last_copy)) ? '0 : fire ? off_sx_q + h_dsx : off_sx_q;
    off_sy_d = (flush || (fire && out_last_copy)) ? '0 : fire ? off_sy_q + h_dsy : off_sy_q;
    overflow_d = overflow_q || (memory_instruction_we && queue_full);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx_q <= '0;
      off_addr_q <= '0;
      off_sx_q <= '0;
      off_sy_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      off_addr_q <= off_addr_d;
      off_sx_q <= off_sx_d;
      off_sy_q <= off_sy_d;
      overflow_q <= overflow_d;
    end
endmodule

// File: tb/tb_memory_instruction_queue.sv
// tb_memory_instruction_queue: directed self-checking bench for the memory instruction queue
module tb_memory_instruction_queue;
  logic clk = 1'b0;
  logic reset, flush, memory_instruction_we, out_ready;
  logic [104:0] memory_instructions;
  logic [1:0] copy_count;
  logic queue_full, queue_almost_full, overflow_error, out_valid;
  logic [3:0] occupancy;
  logic out_is_load, out_zero_flag, out_skip_flag, out_last_copy;
  logic [1:0] out_target, out_copy_index;
  logic [4:0] out_height, out_width;
  logic [14:0] out_addr, out_stridex, out_stridey;
  int passed = 0;
  int total = 0;

  memory_instruction_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .memory_instructions(memory_instructions), .memory_instruction_we(memory_instruction_we),
    .copy_count(copy_count), .queue_full(queue_full), .queue_almost_full(queue_almost_full),
    .occupancy(occupancy), .overflow_error(overflow_error), .out_valid(out_valid),
    .out_ready(out_ready), .out_is_load(out_is_load), .out_target(out_target),
    .out_height(out_height), .out_width(out_width), .out_zero_flag(out_zero_flag),
    .out_skip_flag(out_skip_flag), .out_addr(out_addr), .out_stridex(out_stridex),
    .out_stridey(out_stridey), .out_copy_index(out_copy_index), .out_last_copy(out_last_copy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // header fixed at is_load=1 target=2 height=17 width=9 zero=0 skip=1; stridex 100 (-2/copy), stridey 300 (+1/copy)
  task automatic load(input logic [14:0] a, input logic [14:0] da, input logic [1:0] cc);
    memory_instructions = {1'b1, 2'd2, 5'd17, 5'd9, 1'b0, 1'b1, a, 15'd100, 15'd300, da, 15'h7FFE, 15'd1};
    copy_count = cc;
    memory_instruction_we = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; memory_instruction_we = 1'b0; out_ready = 1'b0;
    memory_instructions = '0; copy_count = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_full", 32'(queue_full), 0);
    chk("rst_afull", 32'(queue_almost_full), 0);
    chk("rst_ovf", 32'(overflow_error), 0);

    // three-copy replay
    load(15'd10, 15'd4, 2'd2); out_ready = 1'b1;
    step(); memory_instruction_we = 1'b0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_addr0", 32'(out_addr), 10);
    chk("t1_idx0", 32'(out_copy_index), 0);
    chk("t1_last0", 32'(out_last_copy), 0);
    chk("t1_isload", 32'(out_is_load), 1);
    chk("t1_target", 32'(out_target), 2);
    chk("t1_height", 32'(out_height), 17);
    chk("t1_width", 32'(out_width), 9);
    chk("t1_flags", 32'({out_zero_flag, out_skip_flag}), 1);
    step();
    chk("t1_addr1", 32'(out_addr), 14);
    chk("t1_idx1", 32'(out_copy_index), 1);
    chk("t1_last1", 32'(out_last_copy), 0);
    chk("t1_sx1", 32'(out_stridex), 98);
    step();
    chk("t1_addr2", 32'(out_addr), 18);
    chk("t1_idx2", 32'(out_copy_index), 2);
    chk("t1_last2", 32'(out_last_copy), 1);
    chk("t1_sx2", 32'(out_stridex), 96);
    chk("t1_sy2", 32'(out_stridey), 302);
    step();
    chk("t1_empty_valid", 32'(out_valid), 0);
    chk("t1_empty_occ", 32'(occupancy), 0);

    // fill to overflow with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      load(15'(i * 100), 15'd0, 2'd0);
      step();
      if (i == 5) chk("t2_afull6", 32'(queue_almost_full), 0);
      if (i == 6) begin
        chk("t2_afull7", 32'(queue_almost_full), 1);
        chk("t2_full7", 32'(queue_full), 0);
      end
      if (i == 7) begin
        chk("t2_full8", 32'(queue_full), 1);
        chk("t2_ovf8", 32'(overflow_error), 0);
      end
    end
    chk("t2_occ", 32'(occupancy), 8);
    chk("t2_ovf", 32'(overflow_error), 1);

    // full with head on last copy: pop and rejected push together
    load(15'd999, 15'd0, 2'd0); out_ready = 1'b1;
    chk("t4_head", 32'(out_addr), 0);
    chk("t4_last", 32'(out_last_copy), 1);
    step(); memory_instruction_we = 1'b0; out_ready = 1'b0;
    chk("t4_occ", 32'(occupancy), 7);
    chk("t4_ovf", 32'(overflow_error), 1);
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("t4_drain", 32'(out_addr), 32'(i * 100));
      step();
    end
    chk("t4_drained", 32'(out_valid), 0);

    // stall on copy 1 of 4
    out_ready = 1'b0;
    load(15'd50, 15'd5, 2'd3);
    step(); memory_instruction_we = 1'b0;
    chk("t3_addr0", 32'(out_addr), 50);
    out_ready = 1'b1;
    step(); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_addr", 32'(out_addr), 55);
      chk("t3_hold_idx", 32'(out_copy_index), 1);
      step();
    end
    chk("t3_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    chk("t3_resume_idx", 32'(out_copy_index), 1);
    step();
    chk("t3_addr2", 32'(out_addr), 60);
    chk("t3_idx2", 32'(out_copy_index), 2);
    step();
    chk("t3_addr3", 32'(out_addr), 65);
    chk("t3_last3", 32'(out_last_copy), 1);
    step();
    chk("t3_done", 32'(out_valid), 0);

    // address wrap
    load(15'd32766, 15'd3, 2'd1);
    step(); memory_instruction_we = 1'b0;
    chk("t5_addr0", 32'(out_addr), 32766);
    step();
    chk("t5_addr1", 32'(out_addr), 1);
    chk("t5_last", 32'(out_last_copy), 1);
    step();
    chk("t5_done", 32'(out_valid), 0);

    // flush mid-replay with concurrent push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load(15'(1000 + i), 15'd10, 2'd3);
      step();
    end
    memory_instruction_we = 1'b0; out_ready = 1'b1;
    step(); out_ready = 1'b0;
    chk("t6_mid_idx", 32'(out_copy_index), 1);
    chk("t6_mid_occ", 32'(occupancy), 3);
    load(15'd2000, 15'd1, 2'd0); flush = 1'b1;
    step(); flush = 1'b0; memory_instruction_we = 1'b0;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_occ", 32'(occupancy), 0);
    chk("t6_ovf_kept", 32'(overflow_error), 1);
    load(15'd200, 15'd7, 2'd1);
    step(); memory_instruction_we = 1'b0;
    chk("t6_fresh_idx", 32'(out_copy_index), 0);
    chk("t6_fresh_addr", 32'(out_addr), 200);
    chk("t6_fresh_sx", 32'(out_stridex), 100);
    out_ready = 1'b1;
    step();
    chk("t6_fresh_addr1", 32'(out_addr), 207);
    chk("t6_fresh_idx1", 32'(out_copy_index), 1);

    // asynchronous reset mid-replay
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t7_occ", 32'(occupancy), 0);
    chk("t7_valid", 32'(out_valid), 0);
    chk("t7_ovf", 32'(overflow_error), 0);
    #1 reset = 1'b0;
    load(15'd5, 15'd1, 2'd0);
    step(); memory_instruction_we = 1'b0;
    chk("t7_idx", 32'(out_copy_index), 0);
    chk("t7_addr", 32'(out_addr), 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/memory_instruction_queue.md
Name: memory_instruction_queue

Overview:
- Receiving end of the control unit's memory-instruction write port.
- Buffers packed memory instructions and their copy counts in a FIFO, then unpacks them.
- Replays each instruction (copy_count+1) times toward the APU/memory issue stage over a valid/ready handshake, advancing addresses by the delta fields on each copy.
- Back-pressures the control unit with full/almost-full so it can hold in its stall state.

Parameters:
MEMORY_ADDRESS_BITS, 15, width of each address/stride field
SUPERSCALAR_LOG_WIDTH, 2, width of copy_count; max copies = 2^SUPERSCALAR_LOG_WIDTH
QUEUE_LOG_DEPTH, 3, FIFO depth = 2^QUEUE_LOG_DEPTH entries
MEM_INSTR_WIDTH, 6*MEMORY_ADDRESS_BITS+15, packed word width (derived; do not override)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous: discard all entries and any copy in progress
memory_instructions  input  MEM_INSTR_WIDTH  packed instruction word
memory_instruction_we  input  1  push strobe
copy_count  input  SUPERSCALAR_LOG_WIDTH  extra copies (0 means 1 issue)
queue_full  output  1  occupancy == depth
queue_almost_full  output  1  occupancy >= depth-1
occupancy  output  QUEUE_LOG_DEPTH+1  entry count
overflow_error  output  1  sticky: push attempted while full
out_valid  output  1  head copy available
out_ready  input  1  consumer accepts
out_is_load  output  1  unpacked field
out_target  output  2  unpacked field
out_height  output  5  unpacked field
out_width  output  5  unpacked field
out_zero_flag  output  1  unpacked field
out_skip_flag  output  1  unpacked field
out_addr  output  MEMORY_ADDRESS_BITS  addr plus accumulated daddr
out_stridex  output  MEMORY_ADDRESS_BITS  stridex plus accumulated dstridex
out_stridey  output  MEMORY_ADDRESS_BITS  stridey plus accumulated dstridey
out_copy_index  output  SUPERSCALAR_LOG_WIDTH  current copy number, 0-based
out_last_copy  output  1  out_copy_index == head copy_count

Behaviour:
- Packed layout, MSB to LSB: is_load(1), target(2), height(5), width(5), zero_flag(1), skip_flag(1), addr, stridex, stridey, daddr, dstridex, dstridey (MEMORY_ADDRESS_BITS each; all signed).
- Entry stores {word, copy_count}.
- Reset: pointers, occupancy, copy index and offsets = 0; overflow_error = 0; out_valid = 0; queue_full = 0; queue_almost_full = 0.
- Push:
  - Occurs when memory_instruction_we && !queue_full.
  - Entry is visible at the head the next cycle, so out_valid rises 1 cycle after the push into an empty queue. There is no combinational bypass.
- Push while full:
  - Word is dropped and overflow_error is set.
  - This holds even if a pop completes the same cycle; full is evaluated pre-pop.
  - overflow_error clears only on reset.
- out_valid = occupancy != 0. Head fields are driven combinationally from the head entry and offset registers.
- Issue handshake: out_valid && out_ready.
  - If !out_last_copy: copy_index++, off_addr += daddr, off_sx += dstridex, off_sy += dstridey. Entry is retained.
  - If out_last_copy: pop the entry; copy_index and offsets return to 0 in the same edge.
- Arithmetic:
  - out_addr = head.addr + off_addr, truncated to MEMORY_ADDRESS_BITS (wraps modulo 2^MAB, no saturation).
  - out_stridex and out_stridey are formed the same way from their own fields and offsets.
- Simultaneous push and pop with queue not full: both occur and occupancy is unchanged.
- Pointers wrap modulo depth. Occupancy is one bit wider so full and empty are distinguished.
- Outputs with out_valid = 0 are don't-care. The bench must not check them.
- Consumer rule: out_valid is not withdrawn until the handshake; fields are stable while out_valid && !out_ready.
- flush:
  - Next cycle occupancy = 0, copy_index = 0, offsets = 0.
  - A push coinciding with flush is discarded.
  - flush has priority over push and pop. overflow_error is unaffected.
- Reset asserted mid-replay: all state is cleared asynchronously and the partially issued instruction is lost.

Decomposition:
- Shared package (with the decoder typedefs): the packed field widths and offsets, plus a packed struct for the memory-instruction word.
  - The control unit packs with the same struct, so the two ends cannot drift.
- Sub-module sync_fifo, parameterized by width and log depth.
  - Provides push/pop, full/empty/count and registered storage.
  - This block adds the replay counter, the offset accumulators and the unpacking.

Test Plan:
- Reset, then push addr=10, daddr=4, copy_count=2, out_ready=1 -> out_valid rises next cycle; out_addr 10,14,18 on three consecutive cycles; out_copy_index 0,1,2; out_last_copy only on the third; queue is empty after.
- Push 9 words back-to-back with out_ready=0, depth 8 -> queue_almost_full after the 7th, queue_full after the 8th; 9th dropped; overflow_error=1; occupancy=8.
- Hold out_ready=0 for 5 cycles on copy 1 of 4 -> outputs stable; release -> replay resumes at copy 1, no copies skipped or repeated.
- Queue full and head on its last copy, with push and out_ready the same cycle -> pop occurs, push is rejected, overflow_error=1, occupancy=7.
- addr=2^15-2, daddr=3, copy_count=1 -> out_addr = 32766 then 1 (wrap).
- flush mid-replay with 3 entries plus a concurrent push -> next cycle out_valid=0 and occupancy=0; a fresh push then issues from copy_index 0 with zero offsets.
